// File: rtl/alarm_pkg.sv
// Shared types and helpers for the alarm controller: state encoding and timer sizing.
package alarm_pkg;

    typedef enum logic [2:0] {
        DISARMED   = 3'd0,
        EXIT_WAIT  = 3'd1,
        ARMED      = 3'd2,
        ENTRY_WAIT = 3'd3,
        ALARM      = 3'd4
    } alarm_state_t;

    // Width of a down-counter able to hold the longest of the three delays.
    function automatic int timer_width(input int exit_cyc, input int entry_cyc, input int siren_cyc);
        int longest;
        longest = exit_cyc;
        if (entry_cyc > longest) longest = entry_cyc;
        if (siren_cyc > longest) longest = siren_cyc;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/alarm_timer.sv
// Saturating down-counter shared by the exit, entry and siren delays.
// done is high whenever the count has reached zero.
module alarm_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic         done
);

    logic [W-1:0] count;

    // Load has priority over counting; the count stops at zero instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (tick && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/alarm_ctrl.sv
// Arm/disarm alarm state machine with exit/entry delays, per-zone bypass,
// instant/delayed zone classes, a latched trip record and a bounded siren.
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int N_SEN     = 4,
    parameter int EXIT_CYC  = 16,
    parameter int ENTRY_CYC = 16,
    parameter int SIREN_CYC = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SEN-1:0] sen,
    input  logic             en,
    input  logic [N_SEN-1:0] bypass,
    input  logic [N_SEN-1:0] delay_zone,
    output logic             alarm_out,
    output logic             armed,
    output logic             warn,
    output logic [N_SEN-1:0] trip,
    output logic [2:0]       state
);

    localparam int TW = timer_width(EXIT_CYC, ENTRY_CYC, SIREN_CYC);

    // The timer reports done once it has counted down to zero, and the
    // transition happens on the following edge, so loading L-1 yields
    // exactly L cycles spent in the timed state.
    localparam logic [TW-1:0] EXIT_LD  = TW'(EXIT_CYC - 1);
    localparam logic [TW-1:0] ENTRY_LD = TW'(ENTRY_CYC - 1);
    localparam logic [TW-1:0] SIREN_LD = TW'(SIREN_CYC - 1);

    alarm_state_t     state_q;
    alarm_state_t     state_d;
    logic [N_SEN-1:0] trip_d;
    logic [N_SEN-1:0] v;
    logic             inst_hit;
    logic             del_hit;
    logic             timer_load;
    logic [TW-1:0]    timer_val;
    logic             timer_tick;
    logic             timer_done;

    assign v        = sen & ~bypass;
    assign inst_hit = |(v & ~delay_zone);
    assign del_hit  = |(v & delay_zone);

    // Only the timed states consume the counter; elsewhere it just holds.
    assign timer_tick = (state_q == EXIT_WAIT) || (state_q == ENTRY_WAIT) || (state_q == ALARM);

    alarm_timer #(
        .W(TW)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (timer_load),
        .load_val(timer_val),
        .tick    (timer_tick),
        .done    (timer_done)
    );

    // Next-state, timer load and trip update; disarm beats every other transition.
    always_comb begin
        state_d    = state_q;
        trip_d     = trip;
        timer_load = 1'b0;
        timer_val  = '0;
        if (!en) begin
            state_d = DISARMED;
        end else begin
            case (state_q)
                DISARMED: begin
                    state_d    = EXIT_WAIT;
                    trip_d     = '0;
                    timer_load = 1'b1;
                    timer_val  = EXIT_LD;
                end
                EXIT_WAIT: begin
                    if (timer_done) state_d = ARMED;
                end
                ARMED: begin
                    if (inst_hit) begin
                        state_d    = ALARM;
                        trip_d     = trip | v;
                        timer_load = 1'b1;
                        timer_val  = SIREN_LD;
                    end else if (del_hit) begin
                        state_d    = ENTRY_WAIT;
                        trip_d     = trip | v;
                        timer_load = 1'b1;
                        timer_val  = ENTRY_LD;
                    end
                end
                ENTRY_WAIT: begin
                    trip_d = trip | v;
                    if (inst_hit || timer_done) begin
                        state_d    = ALARM;
                        timer_load = 1'b1;
                        timer_val  = SIREN_LD;
                    end
                end
                ALARM: begin
                    trip_d = trip | v;
                    if (timer_done) state_d = ARMED;
                end
                default: begin
                    state_d = DISARMED;
                end
            endcase
        end
    end

    // State, trip record and output decodes, all registered from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= DISARMED;
            trip      <= '0;
            alarm_out <= 1'b0;
            armed     <= 1'b0;
            warn      <= 1'b0;
        end else begin
            state_q   <= state_d;
            trip      <= trip_d;
            alarm_out <= (state_d == ALARM);
            armed     <= (state_d == ARMED) || (state_d == ENTRY_WAIT) || (state_d == ALARM);
            warn      <= (state_d == EXIT_WAIT) || (state_d == ENTRY_WAIT);
        end
    end

    assign state = state_q;

endmodule
